instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/instr_fetch.sv | 88 ++++++++
 tb/tb_instr_fetch.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - two-entry {pc, instr} buffer with push/pop/flush
module fetch_fifo #(
  parameter int Width = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [Width-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  // A pop on empty is dropped; a push on full is only legal when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop  = pop_i & (count_q != 2'd0);
    do_push = push_i & ((count_q != 2'd2) | do_pop);
  end

  // Pointer and occupancy tracking; flush empties the buffer regardless of push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Entry storage; contents are don't-care after reset so no reset is applied.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i && !rst) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - sequential instruction fetch with redirect, 2-entry buffer and fault trap
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                   Word_size = 32,
  parameter int                   Addr_bits = 32,
  parameter logic [Addr_bits-1:0] RESET_PC  = Addr_bits'(DEFAULT_RESET_PC)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [Addr_bits-1:0] imem_addr,
  input  logic [Word_size-1:0] imem_instr,
  input  logic                 redirect_valid,
  input  logic [Addr_bits-1:0] redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Word_size-1:0] out_instr,
  output logic [Addr_bits-1:0] out_pc,
  output logic                 out_fault
);

  localparam int EntryW = Addr_bits + Word_size;

  fetch_state_e         state_q, state_d;
  logic [Addr_bits-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]           count;
  logic [EntryW-1:0]    head;
  logic                 pop;
  logic                 push;
  logic                 flush;
  logic                 redirect_take;
  logic                 misaligned;

  fetch_fifo #(
    .Width(EntryW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i({fetch_pc_q, imem_instr}),
    .pop_i      (pop),
    .flush_i    (flush),
    .head_o     (head),
    .count_o    (count)
  );

  assign imem_addr = fetch_pc_q;
  assign out_valid = (count != 2'd0);
  assign out_pc    = head[EntryW-1:Word_size];
  assign out_instr = head[Word_size-1:0];
  assign out_fault = (state_q == FAULT);

  // Redirects only matter in RUN; they win over any fetch that cycle, and a misaligned one traps.
  always_comb begin
    pop           = out_valid & out_ready;
    redirect_take = (state_q == RUN) & redirect_valid;
    misaligned    = (redirect_pc[1:0] != 2'b00);
    flush         = redirect_take;
    push          = (state_q == RUN) & ~redirect_valid & ((count != 2'd2) | pop);
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN: begin
        if (redirect_take) begin
          if (misaligned) state_d = FAULT;
          else            fetch_pc_d = redirect_pc;
        end else if (push) begin
          fetch_pc_d = fetch_pc_q + Addr_bits'(4);
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = BOOT;
    endcase
  end

  // Control state and fetch address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr_a, imem_instr_a, out_instr_a, out_pc_a, redir_pc;
  logic        out_valid_a, out_ready_a, out_fault_a, redir_v;
  logic [31:0] imem_addr_b, imem_instr_b, out_instr_b, out_pc_b;
  logic        out_valid_b, out_fault_b;
  logic        out_ready_b, redir_v_b;
  logic [31:0] redir_pc_b;
  int          n_checks;
  int          n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)      return 32'h0000_0093;
    else if (a == 32'h4) return 32'h0010_0193;
    else                 return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  always_comb imem_instr_a = mem_word(imem_addr_a);
  always_comb imem_instr_b = mem_word(imem_addr_b);

  instr_fetch dut_a (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr_a),
    .imem_instr    (imem_instr_a),
    .redirect_valid(redir_v),
    .redirect_pc   (redir_pc),
    .out_valid     (out_valid_a),
    .out_ready     (out_ready_a),
    .out_instr     (out_instr_a),
    .out_pc        (out_pc_a),
    .out_fault     (out_fault_a)
  );

  instr_fetch #(
    .RESET_PC(32'hFFFF_FFF8)
  ) dut_b (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr_b),
    .imem_instr    (imem_instr_b),
    .redirect_valid(redir_v_b),
    .redirect_pc   (redir_pc_b),
    .out_valid     (out_valid_b),
    .out_ready     (out_ready_b),
    .out_instr     (out_instr_b),
    .out_pc        (out_pc_b),
    .out_fault     (out_fault_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    out_ready_a = 1'b1;
    redir_v     = 1'b0;
    redir_pc    = 32'h0;
    out_ready_b = 1'b1;
    redir_v_b   = 1'b0;
    redir_pc_b  = 32'h0;

    // reset state
    step();
    step();
    chk("rst_valid", 32'(out_valid_a), 32'd0);
    chk("rst_fault", 32'(out_fault_a), 32'd0);
    chk("rst_addr_a", imem_addr_a, 32'h0);
    chk("rst_addr_b", imem_addr_b, 32'hFFFF_FFF8);

    // reset release, streaming with out_ready=1
    rst = 1'b0;
    step();
    chk("boot_valid_a", 32'(out_valid_a), 32'd0);
    chk("boot_valid_b", 32'(out_valid_b), 32'd0);
    step();
    chk("first_valid", 32'(out_valid_a), 32'd1);
    chk("first_pc", out_pc_a, 32'h0);
    chk("first_instr", out_instr_a, 32'h0000_0093);
    chk("wrap_pc0", out_pc_b, 32'hFFFF_FFF8);
    step();
    chk("second_pc", out_pc_a, 32'h4);
    chk("second_instr", out_instr_a, 32'h0010_0193);
    chk("wrap_pc1", out_pc_b, 32'hFFFF_FFFC);
    step();
    chk("third_pc", out_pc_a, 32'h8);
    chk("third_instr", out_instr_a, mem_word(32'h8));
    chk("wrap_pc2", out_pc_b, 32'h0);
    chk("wrap_valid", 32'(out_valid_b), 32'd1);

    // backpressure from reset
    rst = 1'b1;
    step();
    rst         = 1'b0;
    out_ready_a = 1'b0;
    step();
    step();
    step();
    chk("bp_addr_e3", imem_addr_a, 32'h8);
    step();
    step();
    chk("bp_addr_e5", imem_addr_a, 32'h8);
    chk("bp_head_pc", out_pc_a, 32'h0);
    chk("bp_head_instr", out_instr_a, 32'h0000_0093);
    chk("bp_valid", 32'(out_valid_a), 32'd1);
    out_ready_a = 1'b1;
    step();
    chk("bp_drain_pc4", out_pc_a, 32'h4);
    step();
    chk("bp_drain_pc8", out_pc_a, 32'h8);

    // refill then redirect while full and popping
    out_ready_a = 1'b0;
    step();
    chk("full_head", out_pc_a, 32'h8);
    chk("full_addr", imem_addr_a, 32'h10);
    out_ready_a = 1'b1;
    redir_v     = 1'b1;
    redir_pc    = 32'h18;
    step();
    redir_v = 1'b0;
    chk("redir_flush_valid", 32'(out_valid_a), 32'd0);
    chk("redir_addr", imem_addr_a, 32'h18);
    step();
    chk("redir_valid", 32'(out_valid_a), 32'd1);
    chk("redir_pc", out_pc_a, 32'h18);
    chk("redir_instr", out_instr_a, mem_word(32'h18));
    step();
    chk("redir_next_pc", out_pc_a, 32'h1C);

    // misaligned redirect traps
    redir_v  = 1'b1;
    redir_pc = 32'h1A;
    step();
    chk("fault_flag", 32'(out_fault_a), 32'd1);
    chk("fault_valid", 32'(out_valid_a), 32'd0);
    chk("fault_addr", imem_addr_a, 32'h20);
    redir_pc = 32'h0;
    step();
    redir_v = 1'b0;
    chk("fault_ign_flag", 32'(out_fault_a), 32'd1);
    chk("fault_ign_valid", 32'(out_valid_a), 32'd0);
    chk("fault_ign_addr", imem_addr_a, 32'h20);
    step();
    chk("fault_hold_flag", 32'(out_fault_a), 32'd1);
    chk("fault_hold_addr", imem_addr_a, 32'h20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("fault_clr_flag", 32'(out_fault_a), 32'd0);
    chk("fault_clr_valid", 32'(out_valid_a), 32'd0);
    chk("fault_clr_addr", imem_addr_a, 32'h0);

    // reset with two entries buffered and a pending redirect
    out_ready_a = 1'b0;
    step();
    step();
    step();
    chk("mid_full_valid", 32'(out_valid_a), 32'd1);
    chk("mid_full_addr", imem_addr_a, 32'h8);
    rst      = 1'b1;
    redir_v  = 1'b1;
    redir_pc = 32'h40;
    step();
    chk("mid_rst_valid", 32'(out_valid_a), 32'd0);
    chk("mid_rst_addr", imem_addr_a, 32'h0);
    rst         = 1'b0;
    redir_v     = 1'b0;
    out_ready_a = 1'b1;
    step();
    chk("mid_boot_valid", 32'(out_valid_a), 32'd0);
    chk("mid_boot_addr", imem_addr_a, 32'h0);
    step();
    chk("mid_restart_valid", 32'(out_valid_a), 32'd1);
    chk("mid_restart_pc", out_pc_a, 32'h0);
    chk("mid_restart_fault", 32'(out_fault_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
